pc_unit_spec: RTL and testbench

Parametrised program-counter unit for the word-addressed pipelined core, successor to the fixed 3-stage PC. Generates the fetch address and a fetch-valid qualifier every cycle and resolves branches/jumps at a configurable pipeline depth. Supports two modes: freeze-on-control (bubble until resolution) and speculative fall-through (predict not-taken, flush on taken). Provides performance counters. Sits between the hazard unit, instruction memory and the resolving (write-back) stage.

---
 rtl/pc_unit_spec_pkg.sv | 13 +
 rtl/pc_unit_spec_target_calc.sv | 30 +++
 rtl/pc_unit_spec.sv | 68 ++++++
 tb/tb_pc_unit_spec.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pc_unit_spec_pkg.sv
// pc_pkg: control opcodes and classification shared by the PC unit and its target calculator
package pc_pkg;
  localparam logic [5:0] OP_BEQ = 6'd32;
  localparam logic [5:0] OP_BNE = 6'd33;
  localparam logic [5:0] OP_BLT = 6'd34;
  localparam logic [5:0] OP_BLE = 6'd35;
  localparam logic [5:0] OP_J   = 6'd40;
  localparam logic [5:0] OP_JAL = 6'd41;
  localparam logic [5:0] OP_JR  = 6'd42;
  function automatic logic is_ctl(input logic [5:0] op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BLE, OP_J, OP_JAL, OP_JR};
  endfunction
endpackage

// File: rtl/pc_unit_spec_target_calc.sv
// pc_target_calc: taken decision and redirect target for the resolving instruction
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SIGNED_CMP = 0
) (
  input  logic [5:0]      res_op,
  input  logic [XLEN-1:0] res_os,
  input  logic [XLEN-1:0] res_ot,
  input  logic [25:0]     res_addr,
  input  logic [XLEN-1:0] res_imm,
  input  logic [XLEN-1:0] res_pc,
  output logic            taken,
  output logic [XLEN-1:0] target
);
  logic eq, lt;
  assign eq = res_os == res_ot;
  assign lt = (SIGNED_CMP != 0) ? ($signed(res_os) < $signed(res_ot)) : (res_os < res_ot);
  // Branch displacement is in bytes; the PC counts words.
  always_comb begin
    taken  = res_op == OP_BEQ ? eq :
             res_op == OP_BNE ? !eq :
             res_op == OP_BLT ? lt :
             res_op == OP_BLE ? (lt || eq) : is_ctl(res_op);
    target = res_op == OP_JR ? res_os :
             (res_op == OP_J || res_op == OP_JAL) ? XLEN'(res_addr[25:2]) :
             res_pc + XLEN'($signed(res_imm) >>> 2);
  end
endmodule

// File: rtl/pc_unit_spec.sv
// pc_unit_spec: fetch PC generator with freeze or predict-not-taken control handling and perf counters
module pc_unit_spec
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              DEPTH      = 3,
  parameter int              SPECULATE  = 0,
  parameter int              SIGNED_CMP = 0,
  parameter int              CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rstd,
  input  logic             stall,
  input  logic [5:0]       if_op,
  input  logic [5:0]       res_op,
  input  logic [XLEN-1:0]  res_os,
  input  logic [XLEN-1:0]  res_ot,
  input  logic [25:0]      res_addr,
  input  logic [XLEN-1:0]  res_imm,
  input  logic [XLEN-1:0]  res_pc,
  output logic [XLEN-1:0]  pc_out,
  output logic             fetch_valid,
  output logic             flush,
  output logic [CNT_W-1:0] cnt_cycle,
  output logic [CNT_W-1:0] cnt_bubble,
  output logic [CNT_W-1:0] cnt_flush
);
  logic [XLEN-1:0]  pc_q, pc_d, target;
  logic [DEPTH-1:0] ctl_q, ctl_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, bub_q, bub_d, fl_q, fl_d;
  logic             taken, taken_now, freeze;
  pc_target_calc #(.XLEN(XLEN), .SIGNED_CMP(SIGNED_CMP)) u_tgt (
    .res_op(res_op), .res_os(res_os), .res_ot(res_ot), .res_addr(res_addr),
    .res_imm(res_imm), .res_pc(res_pc), .taken(taken), .target(target)
  );
  // The oldest pipe bit is the resolving op itself, so it never freezes fetch.
  assign freeze = (SPECULATE == 0) && (|ctl_q[DEPTH-2:0]);
  always_comb begin
    taken_now   = !stall && taken;
    fetch_valid = !stall && !freeze && !taken_now;
    flush       = (SPECULATE != 0) && taken_now;
    pc_d        = stall ? pc_q : taken_now ? target : freeze ? pc_q : pc_q + XLEN'(1);
    ctl_d       = stall ? ctl_q : flush ? '0 : {ctl_q[DEPTH-2:0], fetch_valid && is_ctl(if_op)};
    cyc_d       = cyc_q + CNT_W'(1);
    bub_d       = bub_q + CNT_W'(!fetch_valid);
    fl_d        = fl_q + CNT_W'(flush);
  end
  always_ff @(posedge clk) begin
    if (rstd) begin
      pc_q  <= RESET_PC;
      ctl_q <= '0;
      cyc_q <= '0;
      bub_q <= '0;
      fl_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      ctl_q <= ctl_d;
      cyc_q <= cyc_d;
      bub_q <= bub_d;
      fl_q  <= fl_d;
    end
  end
  assign pc_out     = pc_q;
  assign cnt_cycle  = cyc_q;
  assign cnt_bubble = bub_q;
  assign cnt_flush  = fl_q;
endmodule

// File: tb/tb_pc_unit_spec.sv
// tb_pc_unit_spec: directed checks of freeze (dut0) and speculative (dut1) PC unit instances
module tb_pc_unit_spec;
  logic        clk = 0;
  logic        rstd, stall;
  logic [5:0]  if_op, res_op;
  logic [31:0] res_os, res_ot, res_imm, res_pc;
  logic [25:0] res_addr;
  logic [31:0] pc0, pc1, cc0, cb0, cf0, cc1, cb1, cf1;
  logic        fv0, fv1, fl0, fl1;
  int          n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  pc_unit_spec #(.SPECULATE(0)) dut0 (
    .clk(clk), .rstd(rstd), .stall(stall), .if_op(if_op), .res_op(res_op),
    .res_os(res_os), .res_ot(res_ot), .res_addr(res_addr), .res_imm(res_imm),
    .res_pc(res_pc), .pc_out(pc0), .fetch_valid(fv0), .flush(fl0),
    .cnt_cycle(cc0), .cnt_bubble(cb0), .cnt_flush(cf0)
  );
  pc_unit_spec #(.SPECULATE(1)) dut1 (
    .clk(clk), .rstd(rstd), .stall(stall), .if_op(if_op), .res_op(res_op),
    .res_os(res_os), .res_ot(res_ot), .res_addr(res_addr), .res_imm(res_imm),
    .res_pc(res_pc), .pc_out(pc1), .fetch_valid(fv1), .flush(fl1),
    .cnt_cycle(cc1), .cnt_bubble(cb1), .cnt_flush(cf1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rstd = 1;
    tick();
    rstd = 0;
    #1;
  endtask
  initial begin
    rstd = 1; stall = 0; if_op = 0; res_op = 0;
    res_os = 0; res_ot = 0; res_addr = 0; res_imm = 0; res_pc = 0;
    tick();
    tick();
    rstd = 0;
    #1;
    chk("rst_pc0", pc0, 0);
    chk("rst_pc1", pc1, 0);
    chk("rst_cyc", cc0, 0);
    chk("rst_fv", fv0, 1);
    chk("rst_flush", fl1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", pc0, i);
      chk("seq_fv", fv0, 1);
      tick();
    end
    chk("seq_pc4", pc0, 4);
    chk("seq_cyc4", cc0, 4);
    chk("seq_bub0", cb0, 0);
    tick();
    if_op = 32;
    #1;
    chk("frz_pc5", pc0, 5);
    chk("frz_fv_fetch", fv0, 1);
    tick();
    if_op = 0;
    #1;
    chk("frz_pc6a", pc0, 6);
    chk("frz_fv_a", fv0, 0);
    tick();
    chk("frz_pc6b", pc0, 6);
    chk("frz_fv_b", fv0, 0);
    tick();
    res_op = 32; res_os = 7; res_ot = 7; res_imm = 16; res_pc = 6;
    #1;
    chk("frz_res_fv", fv0, 0);
    chk("frz_res_flush", fl0, 0);
    chk("frz_res_pc", pc0, 6);
    tick();
    res_op = 0;
    #1;
    chk("frz_tgt_pc", pc0, 10);
    chk("frz_bub3", cb0, 3);
    chk("frz_fv_after", fv0, 1);
    chk("frz_cflush", cf0, 0);
    do_reset();
    repeat (5) tick();
    if_op = 33;
    #1;
    chk("spec_pc5", pc1, 5);
    chk("spec_fv5", fv1, 1);
    tick();
    if_op = 0;
    #1;
    chk("spec_pc6", pc1, 6);
    chk("spec_fv6", fv1, 1);
    tick();
    chk("spec_pc7", pc1, 7);
    tick();
    res_op = 33; res_os = 3; res_ot = 3;
    #1;
    chk("spec_nt_fv", fv1, 1);
    chk("spec_nt_flush", fl1, 0);
    chk("spec_pc8", pc1, 8);
    tick();
    res_op = 34; res_os = 32'hFFFF_FFFF; res_ot = 0;
    #1;
    chk("spec_pc9", pc1, 9);
    chk("spec_blt_unsigned_nt", fl1, 0);
    chk("spec_bub0", cb1, 0);
    res_op = 42; res_os = 32'h40;
    #1;
    chk("jr_flush", fl1, 1);
    chk("jr_fv", fv1, 0);
    tick();
    res_op = 0;
    #1;
    chk("jr_pc", pc1, 32'h40);
    chk("jr_flush_off", fl1, 0);
    chk("jr_cflush", cf1, 1);
    chk("jr_bub", cb1, 1);
    chk("jr_fv_after", fv1, 1);
    do_reset();
    tick();
    tick();
    stall = 1; res_op = 32; res_os = 1; res_ot = 1; res_imm = 16; res_pc = 6;
    #1;
    chk("stl_fv", fv0, 0);
    chk("stl_flush", fl1, 0);
    chk("stl_pc", pc0, 2);
    tick();
    chk("stl_pc_hold", pc0, 2);
    chk("stl_pc_hold1", pc1, 2);
    stall = 0;
    #1;
    chk("stl_rel_fv", fv0, 0);
    chk("stl_rel_flush", fl1, 1);
    tick();
    res_op = 0;
    #1;
    chk("stl_tgt0", pc0, 10);
    chk("stl_tgt1", pc1, 10);
    chk("stl_cyc", cc0, 4);
    chk("stl_bub", cb0, 2);
    if_op = 32;
    tick();
    if_op = 0;
    #1;
    chk("rf_frozen", fv0, 0);
    rstd = 1;
    tick();
    rstd = 0;
    #1;
    chk("rf_pc", pc0, 0);
    chk("rf_cyc", cc0, 0);
    chk("rf_bub", cb0, 0);
    chk("rf_fv", fv0, 1);
    res_op = 41; res_addr = 26'h100;
    #1;
    chk("rf_ctl_fv", fv0, 0);
    tick();
    res_op = 0;
    #1;
    chk("jal_pc", pc0, 32'h40);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
